// File: rtl/md_if.sv
// ============================================================================
// Module      : md_if
// Description : Request/result bundle between the execute stage and md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdop, a, b,
        output busy, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Fixed-latency multiply/divide unit owning the HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_if.slave       bus
);

    localparam int C_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int C_CNT_W      = $clog2(C_MAX_CYCLES + 1);

    localparam logic [C_CNT_W-1:0] C_MULT_LD = C_CNT_W'(MULT_CYCLES);
    localparam logic [C_CNT_W-1:0] C_DIV_LD  = C_CNT_W'(DIV_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [31:0]        r_res_hi;
    logic [31:0]        r_res_lo;
    logic               r_commit;
    logic [31:0]        r_arch_hi;
    logic [31:0]        r_arch_lo;

    logic               w_is_md;
    logic               w_done;
    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic        [31:0] w_b_safe;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;

    assign w_is_md = (bus.mdop >= C_OP_MULT) && (bus.mdop <= C_OP_DIVU);
    assign w_done  = (r_state == S_RUN) && (r_cnt == C_CNT_ONE);

    // ------------------------------------------------------------------------
    // Arithmetic, evaluated on the request cycle and captured into r_res_*
    // ------------------------------------------------------------------------
    assign w_sprod  = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    assign w_uprod  = {32'd0, bus.a} * {32'd0, bus.b};
    // Divisor forced non-zero so the divider never sees x; zero is handled by r_commit.
    assign w_b_safe = (bus.b == 32'd0) ? 32'd1 : bus.b;
    assign w_sa     = $signed(bus.a);
    assign w_sb     = $signed(w_b_safe);
    assign w_uquo   = bus.a / w_b_safe;
    assign w_urem   = bus.a % w_b_safe;

    always_comb begin
        w_squo = w_sa / w_sb;
        w_srem = w_sa % w_sb;
        // The single signed overflow case is pinned so it never depends on the simulator.
        if ((bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF)) begin
            w_squo = 32'sh8000_0000;
            w_srem = 32'sd0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_is_md) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == C_CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (all driven from registers)
    // ------------------------------------------------------------------------
    always_comb begin
        bus.busy = (r_state == S_RUN);
        bus.hi   = r_arch_hi;
        bus.lo   = r_arch_lo;
    end

    // ------------------------------------------------------------------------
    // Datapath: counter, pending result, architectural HI/LO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_res_hi  <= 32'd0;
            r_res_lo  <= 32'd0;
            r_commit  <= 1'b0;
            r_arch_hi <= 32'd0;
            r_arch_lo <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (bus.start) begin
                case (bus.mdop)
                    C_OP_MULT: begin
                        r_res_hi <= w_sprod[63:32];
                        r_res_lo <= w_sprod[31:0];
                        r_commit <= 1'b1;
                        r_cnt    <= C_MULT_LD;
                    end
                    C_OP_MULTU: begin
                        r_res_hi <= w_uprod[63:32];
                        r_res_lo <= w_uprod[31:0];
                        r_commit <= 1'b1;
                        r_cnt    <= C_MULT_LD;
                    end
                    C_OP_DIV: begin
                        r_res_hi <= w_srem;
                        r_res_lo <= w_squo;
                        r_commit <= (bus.b != 32'd0);
                        r_cnt    <= C_DIV_LD;
                    end
                    C_OP_DIVU: begin
                        r_res_hi <= w_urem;
                        r_res_lo <= w_uquo;
                        r_commit <= (bus.b != 32'd0);
                        r_cnt    <= C_DIV_LD;
                    end
                    C_OP_MTHI: r_arch_hi <= bus.a;
                    C_OP_MTLO: r_arch_lo <= bus.a;
                    default: ;
                endcase
            end
        end else begin
            // RUN: requests are ignored; the hazard unit keeps them from arriving.
            r_cnt <= r_cnt - C_CNT_ONE;
            if (w_done && r_commit) begin
                r_arch_hi <= r_res_hi;
                r_arch_lo <= r_res_lo;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    localparam int C_MULT = 5;
    localparam int C_DIV  = 10;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    md_if u_if ();

    md_unit #(
        .MULT_CYCLES (C_MULT),
        .DIV_CYCLES  (C_DIV)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.start = 1'b1;
        u_if.mdop  = op;
        u_if.a     = a;
        u_if.b     = b;
        tick();
        u_if.start = 1'b0;
        u_if.mdop  = 3'd0;
    endtask

    // Issue an operation, count busy cycles while checking HI/LO hold, then check results.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n_exp,
                          input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cnt;
        int held;
        cnt  = 0;
        held = 1;
        issue(op, a, b);
        while (u_if.busy && cnt < 64) begin
            if (u_if.hi !== old_hi || u_if.lo !== old_lo) held = 0;
            cnt = cnt + 1;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(n_exp));
        check({tag, "_hold"}, 32'(held), 32'd1);
        check({tag, "_hi"}, u_if.hi, exp_hi);
        check({tag, "_lo"}, u_if.lo, exp_lo);
    endtask

    initial begin
        int cnt;
        int flag;
        n_tests    = 0;
        n_fail     = 0;
        u_if.start = 1'b0;
        u_if.mdop  = 3'd0;
        u_if.a     = 32'd0;
        u_if.b     = 32'd0;

        // Reset then idle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_hi", u_if.hi, 32'd0);
        check("rst_lo", u_if.lo, 32'd0);
        flag = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) flag = 0;
        end
        check("idle_stable", 32'(flag), 32'd1);

        // Multiply, signed and unsigned
        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, C_MULT,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, C_MULT,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);

        // Signed divide and the overflow case
        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, C_DIV,
               32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, C_DIV,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);

        // mthi / mtlo land one cycle after the request with no busy
        issue(3'd5, 32'h1111_1111, 32'd0);
        check("mthi_hi", u_if.hi, 32'h1111_1111);
        check("mthi_busy", 32'(u_if.busy), 32'd0);
        issue(3'd6, 32'h2222_2222, 32'd0);
        check("mtlo_lo", u_if.lo, 32'h2222_2222);
        check("mtlo_busy", 32'(u_if.busy), 32'd0);
        check("mtlo_hi_kept", u_if.hi, 32'h1111_1111);

        // Divide by zero with a stray mtlo request during RUN
        cnt = 0;
        issue(3'd4, 32'd5, 32'd0);
        while (u_if.busy && cnt < 64) begin
            cnt = cnt + 1;
            if (cnt == 3) begin
                issue(3'd6, 32'h0000_DEAD, 32'd0);
            end else begin
                tick();
            end
        end
        check("dz_busy_cycles", 32'(cnt), 32'(C_DIV));
        check("dz_hi", u_if.hi, 32'h1111_1111);
        check("dz_lo", u_if.lo, 32'h2222_2222);
        tick();
        check("dz_lo_after", u_if.lo, 32'h2222_2222);
        check("dz_idle", 32'(u_if.busy), 32'd0);

        // Reset on the third busy cycle aborts the multiply
        issue(3'd1, 32'd7, 32'd6);
        tick();
        tick();
        check("abort_busy_pre", 32'(u_if.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_hi", u_if.hi, 32'd0);
        check("abort_lo", u_if.lo, 32'd0);
        flag = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (u_if.lo === 32'h0000_002A || u_if.busy !== 1'b0) flag = 0;
        end
        check("abort_no_result", 32'(flag), 32'd1);

        // Back-to-back: divu accepted in the first cycle after busy falls
        run_op("b2b_mult", 3'd1, 32'd7, 32'd6, C_MULT,
               32'd0, 32'd0, 32'd0, 32'h0000_002A);
        run_op("b2b_divu", 3'd4, 32'd100, 32'd7, C_DIV,
               32'd0, 32'h0000_002A, 32'd2, 32'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/md_unit.md
# md_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. It sits beside the ALU and consumes the same decoded instruction class from the operation decoder. It owns the architectural HI/LO registers and runs mult/multu/div/divu over a fixed number of cycles, raising Busy so the hazard unit can stall later HI/LO users. mthi/mtlo write HI/LO directly.

## Interface
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10: cycles Busy stays high for div/divu (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Start  in  1  single-cycle request; MDOp, A and B are valid in the same cycle
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  in  32  rs operand, already forwarded
- B  in  32  rt operand, already forwarded
- Busy  out  1  high while a mult/div is in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

## Operation
- The unit has two states: IDLE and RUN.
  - In IDLE, Start=1 with MDOp 1–4 computes the result from A and B and latches it into internal result registers (rHI, rLO). The counter loads MULT_CYCLES or DIV_CYCLES. The state moves to RUN.
  - In IDLE, Start=1 with MDOp 5 loads A into HI at the next edge. MDOp 6 loads A into LO at the next edge. The state stays IDLE and Busy stays 0.
  - In IDLE, Start=1 with MDOp 0 or 7 has no effect.
  - In RUN, the counter decrements each cycle. When it reaches 1, the next edge copies rHI→HI and rLO→LO, clears Busy and returns to IDLE.
- Start is ignored entirely while in RUN. The hazard unit stalls on Busy|Start, so this must never occur in correct operation. The bench still checks that such a Start is ignored.
- Arithmetic rules:
  - mult: signed 32×32→64. HI=product[63:32], LO=product[31:0].
  - multu: same as mult, but unsigned.
  - div: signed. LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div edge case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B=0, div or divu): Busy runs for DIV_CYCLES as normal. HI and LO keep their prior values at completion.
- HI and LO change only at a completion edge, or at the edge after an mthi/mtlo request. They hold their old values throughout RUN.
- Reset applies in any state, including mid-RUN. It aborts the operation, and the pending result is discarded.

## Timing
- Reset values: Busy=0, HI=0, LO=0, state IDLE, counter 0, rHI=rLO=0.
- Multiply/divide: Start is sampled at edge t. Busy is high for cycles t+1 through t+N, where N is MULT_CYCLES or DIV_CYCLES. At edge t+N, Busy falls and HI/LO update together, so new values are visible from cycle t+N+1.
- mthi/mtlo: Start is sampled at edge t. HI or LO holds the new value from cycle t+1. There is no Busy pulse.
- Back-to-back: a new Start may be accepted in the first cycle after Busy falls (cycle t+N+1). There is no dead cycle.
- Outputs are registered only. There are no combinational paths from inputs to Busy, HI or LO.

## Test plan
- Reset then idle: hold reset for 2 cycles, then release → Busy=0, HI=0, LO=0, with no change for 20 idle cycles.
- Signed mult, with MULT_CYCLES=5:
  - Stimulus: A=0xFFFFFFFE (−2), B=3, MDOp=1, Start pulse.
  - Busy is high for exactly 5 cycles.
  - HI/LO keep their old values until the falling edge of Busy, then read HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Repeat with multu → HI=0x00000002, LO=0xFFFFFFFA.
- Signed div, with DIV_CYCLES=10:
  - Stimulus: A=0xFFFFFFF9 (−7), B=2, MDOp=3.
  - Busy is high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Overflow case: A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero and stray Start:
  - Preload HI=0x11111111 via mthi and LO=0x22222222 via mtlo. Each lands one cycle after its Start, with Busy staying 0.
  - Issue divu with B=0 → Busy is high for 10 cycles, and HI/LO are unchanged afterwards.
  - Issue a Start for mtlo (A=0xDEAD) during that RUN → it is ignored, and LO stays 0x22222222.
- Reset mid-operation: start mult 7×6, then assert reset on the third Busy cycle → next cycle Busy=0, HI=LO=0, and 0x2A never appears in LO.
- Back-to-back: mult 7×6 completes → LO=0x0000002A. Start divu 100/7 in the first cycle after Busy falls → it is accepted, and after 10 cycles LO=14, HI=2.
